// File: rtl/key_capture.sv
// Keypad key capture: validates scanner codes, debounces press and release, keeps a two-digit history.
// Capture (new_key + digit update) lands DEBOUNCE_CYCLES cycles after the enable cycle; no backpressure, inputs sampled every cycle.
module key_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_pressed,
    input  logic [7:0] total_val,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       new_key,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_CAPTURE  = 3'd2,
        S_HELD     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       code_q, code_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;
    logic             new_key_q, new_key_d;
    logic             code_ok;
    logic             code_match;

    // Exactly one row high and exactly one column low.
    function automatic logic code_valid(input logic [7:0] code);
        return $onehot(code[7:4]) && $onehot(~code[3:0]);
    endfunction

    function automatic logic [3:0] decode_key(input logic [7:0] code);
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] key;
        case (code[7:4])
            4'b1000: row = 2'd0;
            4'b0100: row = 2'd1;
            4'b0010: row = 2'd2;
            default: row = 2'd3;
        endcase
        case (code[3:0])
            4'b0111: col = 2'd0;
            4'b1011: col = 2'd1;
            4'b1101: col = 2'd2;
            default: col = 2'd3;
        endcase
        case ({row, col})
            4'h0:    key = 4'h1;
            4'h1:    key = 4'h2;
            4'h2:    key = 4'h3;
            4'h3:    key = 4'hA;
            4'h4:    key = 4'h4;
            4'h5:    key = 4'h5;
            4'h6:    key = 4'h6;
            4'h7:    key = 4'hB;
            4'h8:    key = 4'h7;
            4'h9:    key = 4'h8;
            4'hA:    key = 4'h9;
            4'hB:    key = 4'hC;
            4'hC:    key = 4'hE;
            4'hD:    key = 4'h0;
            4'hE:    key = 4'hF;
            default: key = 4'hD;
        endcase
        return key;
    endfunction

    assign code_ok    = code_valid(total_val);
    assign code_match = key_pressed && (total_val == code_q);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        new_key_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable && code_ok) begin
                    code_d  = total_val;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!code_match) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // History and pulse are loaded on CAPTURE entry so both are visible during CAPTURE.
                    cnt_d       = '0;
                    state_d     = S_CAPTURE;
                    digit_old_d = digit_new_q;
                    digit_new_d = decode_key(code_q);
                    new_key_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_HELD;
            end
            S_HELD: begin
                if (!key_pressed) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (key_pressed) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= 8'h00;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
            new_key_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            new_key_q   <= new_key_d;
        end
    end

    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign new_key   = new_key_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_capture.sv
// Self-checking bench for key_capture with a history-queue reference model.
module tb_key_capture;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       key_pressed;
    logic [7:0] total_val;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       new_key;
    logic       busy;

    int n_cmp     = 0;
    int n_err     = 0;
    int pulse_cnt = 0;

    logic [3:0] hist[$];
    logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                  '{4'h4, 4'h5, 4'h6, 4'hB},
                                  '{4'h7, 4'h8, 4'h9, 4'hC},
                                  '{4'hE, 4'h0, 4'hF, 4'hD}};

    key_capture #(.DEBOUNCE_CYCLES(N), .CNT_W($clog2(N))) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .key_pressed(key_pressed),
        .total_val  (total_val),
        .digit_new  (digit_new),
        .digit_old  (digit_old),
        .new_key    (new_key),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk_code(input int r, input int c);
        logic [3:0] one;
        one = 4'b1000;
        return {one >> r, ~(one >> c)};
    endfunction

    function automatic logic [7:0] any_code();
        return 8'($urandom);
    endfunction

    function automatic logic [7:0] other_code(input logic [7:0] code);
        logic [7:0] x;
        do x = 8'($urandom); while (x == code);
        return x;
    endfunction

    function automatic logic [7:0] invalid_code();
        logic [7:0] x;
        do x = 8'($urandom);
        while ($countones(x[7:4]) == 1 && $countones(~x[3:0]) == 1);
        return x;
    endfunction

    function automatic logic [3:0] exp_new();
        return (hist.size() > 0) ? hist[$] : 4'h0;
    endfunction

    function automatic logic [3:0] exp_old();
        return (hist.size() > 1) ? hist[$-1] : 4'h0;
    endfunction

    task automatic step(input logic en, input logic kp, input logic [7:0] tv);
        enable      = en;
        key_pressed = kp;
        total_val   = tv;
        @(posedge clk);
        #1;
        if (new_key === 1'b1) pulse_cnt++;
    endtask

    // Full press: hold >= N+2 edges incl. the enable edge, optional short release dropout, rel >= N+1 lows.
    task automatic press(input int r, input int c, input int hold, input int rel, input int dropout);
        logic [7:0] code;
        logic [3:0] key;
        int         p0;
        code = mk_code(r, c);
        key  = keymap[r][c];
        p0   = pulse_cnt;
        for (int i = 0; i < hold; i++) begin
            step((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, (i <= N) ? code : any_code());
            if (i == N) hist.push_back(key);
            n_cmp++;
            if (new_key !== (i == N))
                begin n_err++; $display("FAIL press_pulse key=%0h edge=%0d: got %b want %b", key, i, new_key, (i == N)); end
            if (i == N) begin
                n_cmp++;
                if (digit_new !== exp_new() || digit_old !== exp_old())
                    begin n_err++; $display("FAIL capture_digits key=%0h: got %h/%h want %h/%h", key, digit_new, digit_old, exp_new(), exp_old()); end
            end
        end
        if (dropout > 0) begin
            for (int i = 0; i < dropout; i++) step(1'b0, 1'b0, any_code());
            for (int i = 0; i < 2; i++) step(1'($urandom_range(0, 1)), 1'b1, any_code());
        end
        for (int i = 0; i < rel; i++) step(1'b0, 1'b0, any_code());
        n_cmp++;
        if (pulse_cnt - p0 !== 1)
            begin n_err++; $display("FAIL press_pulse_count key=%0h: got %0d want 1", key, pulse_cnt - p0); end
        n_cmp++;
        if (busy !== 1'b0)
            begin n_err++; $display("FAIL release_idle key=%0h: busy got %b want 0", key, busy); end
        n_cmp++;
        if (digit_new !== exp_new() || digit_old !== exp_old())
            begin n_err++; $display("FAIL hold_digits: got %h/%h want %h/%h", digit_new, digit_old, exp_new(), exp_old()); end
    endtask

    // Enable plus j stable edges (j < N), then a mismatch: never captured.
    task automatic press_abort(input int r, input int c, input int j, input bit by_code);
        logic [7:0] code;
        int         p0;
        code = mk_code(r, c);
        p0   = pulse_cnt;
        for (int i = 0; i <= j; i++) begin
            step(i == 0, 1'b1, code);
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy edge=%0d: got %b want 1", i, busy); end
        end
        if (by_code) step(1'b0, 1'b1, other_code(code));
        else         step(1'b0, 1'b0, code);
        step(1'b0, 1'b0, any_code());
        n_cmp++;
        if (busy !== 1'b0 || pulse_cnt != p0)
            begin n_err++; $display("FAIL abort_idle: busy=%b pulses=%0d want 0/0", busy, pulse_cnt - p0); end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; key_pressed = 1'b0; total_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({digit_new, digit_old, new_key, busy} !== 10'b0)
            begin n_err++; $display("FAIL reset_state: got %h/%h/%b/%b want 0/0/0/0", digit_new, digit_old, new_key, busy); end
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom_range(0, 1)), any_code());
        n_cmp++;
        if (pulse_cnt != 0 || busy !== 1'b0 || digit_new !== 4'h0 || digit_old !== 4'h0)
            begin n_err++; $display("FAIL idle_quiet: pulses=%0d busy=%b digits=%h/%h want 0/0/0/0", pulse_cnt, busy, digit_new, digit_old); end
    endtask

    task automatic test_single();
        press(0, 1, 10, 10, 0);
        n_cmp++;
        if (digit_new !== 4'h2 || digit_old !== 4'h0)
            begin n_err++; $display("FAIL single_press: got %h/%h want 2/0", digit_new, digit_old); end
    endtask

    task automatic test_bouncy();
        logic [7:0] code;
        int         p0;
        code = mk_code(3, 0);
        p0   = pulse_cnt;
        step(1'b1, 1'b1, code);
        step(1'b0, 1'b1, code);
        step(1'b0, 1'b0, code);
        step(1'b0, 1'b1, code);
        repeat (N + 2) step(1'b0, 1'b1, code);
        n_cmp++;
        if (busy !== 1'b0 || pulse_cnt != p0)
            begin n_err++; $display("FAIL bouncy_press: busy=%b pulses=%0d want 0/0", busy, pulse_cnt - p0); end
        step(1'b0, 1'b0, code);
        press(3, 0, N + 6, N + 3, 0);
        n_cmp++;
        if (digit_new !== 4'hE)
            begin n_err++; $display("FAIL bouncy_then_stable: got %h want e", digit_new); end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt;
        press(2, 0, N + 5, N + 2, 0);
        press(3, 3, N + 5, N + 2, 0);
        n_cmp++;
        if (digit_old !== 4'h7 || digit_new !== 4'hD || pulse_cnt - p0 != 2)
            begin n_err++; $display("FAIL sequence_7D: got %h/%h pulses=%0d want d/7 pulses=2", digit_new, digit_old, pulse_cnt - p0); end
    endtask

    task automatic test_held_multikey();
        press(1, 1, 100, N + 2, 2);
        n_cmp++;
        if (digit_new !== 4'h5)
            begin n_err++; $display("FAIL held_five: got %h want 5", digit_new); end
        step(1'b1, 1'b1, 8'b0100_0011);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL multikey_ignored cycle=%0d: busy got %b want 0", i, busy); end
            step(1'b0, 1'b1, 8'b0100_0011);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] code;
        code = mk_code(2, 0);
        step(1'b1, 1'b1, code);
        step(1'b0, 1'b1, code);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({digit_new, digit_old, new_key, busy} !== 10'b0)
            begin n_err++; $display("FAIL reset_mid_debounce: got %h/%h/%b/%b want 0/0/0/0", digit_new, digit_old, new_key, busy); end
        hist.delete();
        @(negedge clk) reset = 1'b0;
        repeat (N + 2) step(1'b0, 1'b1, code);
        code = mk_code(0, 3);
        for (int i = 0; i < N + 3; i++) begin
            step(i == 0, 1'b1, code);
            if (i == N) hist.push_back(4'hA);
        end
        n_cmp++;
        if (digit_new !== 4'hA || busy !== 1'b1)
            begin n_err++; $display("FAIL held_before_reset: got %h busy=%b want a/1", digit_new, busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({digit_new, digit_old, new_key, busy} !== 10'b0)
            begin n_err++; $display("FAIL reset_mid_held: got %h/%h/%b/%b want 0/0/0/0", digit_new, digit_old, new_key, busy); end
        hist.delete();
        @(negedge clk) reset = 1'b0;
        repeat (N + 2) step(1'b0, 1'b0, any_code());
        press(2, 2, N + 4, N + 2, 0);
        n_cmp++;
        if (digit_new !== 4'h9 || digit_old !== 4'h0)
            begin n_err++; $display("FAIL fresh_after_reset: got %h/%h want 9/0", digit_new, digit_old); end
    endtask

    task automatic test_random();
        for (int e = 0; e < 30; e++) begin
            int kind;
            kind = $urandom_range(0, 4);
            if (kind <= 2)
                press($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(N + 2, N + 15),
                      $urandom_range(N + 1, N + 6), (kind == 2) ? $urandom_range(1, N) : 0);
            else if (kind == 3)
                press_abort($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
            else begin
                step(1'b1, 1'($urandom_range(0, 1)), invalid_code());
                n_cmp++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL invalid_enable: busy got %b want 0", busy); end
            end
        end
        n_cmp++;
        if (digit_new !== exp_new() || digit_old !== exp_old())
            begin n_err++; $display("FAIL random_history: got %h/%h want %h/%h", digit_new, digit_old, exp_new(), exp_old()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bouncy();
        test_back_to_back();
        test_held_multikey();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_capture.md
Name: key_capture

Overview:
- Sits directly downstream of the keypad row scanner and consumes its `enable` pulse and its 8-bit `{rows, columns}` code.
- Validates the code, debounces press and release with a cycle counter, and decodes the row/column pair to a 4-bit hex value.
- Maintains a two-digit history (most recent and previous key) for the dual seven-segment display driver.
- Guarantees exactly one history update per physical key press.

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required to accept a press and, separately, to accept a release (must be ≥2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scanner "row has key, first detection" pulse
- key_pressed  input  1  raw any-column-active flag (columns != 4'b1111)
- total_val  input  8  [7:4] one-hot rows, active-high (bit7 = row1); [3:0] columns, active-low (bit3 = column 0, leftmost)
- digit_new  output  4  most recent accepted key
- digit_old  output  4  key accepted before digit_new
- new_key  output  1  single-cycle pulse when the history updates
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high):
  - state = IDLE, counter = 0, latched code = 8'h00.
  - digit_new = 4'h0, digit_old = 4'h0, new_key = 0, busy = 0.
  - Reset asserted mid-debounce or while HELD aborts immediately with no history update.
- Valid code:
  - rows has exactly one bit set.
  - columns has exactly one bit low.
  - Anything else (multi-key, no key) is invalid.
- Decode (row1..row4 × col0..col3):
  - row1: 1 2 3 A
  - row2: 4 5 6 B
  - row3: 7 8 9 C
  - row4: E 0 F D
- State IDLE:
  - If enable = 1 and total_val is valid: latch total_val, counter = 0, go to DEBOUNCE.
  - Otherwise stay in IDLE; invalid codes are ignored silently.
- State DEBOUNCE:
  - If key_pressed = 1 and total_val == latched code: counter++.
  - When counter == DEBOUNCE_CYCLES-1: go to CAPTURE.
  - Any mismatch or key_pressed = 0: go to IDLE, counter = 0.
  - Press acceptance latency: DEBOUNCE_CYCLES cycles after the enable cycle, then CAPTURE.
- State CAPTURE (exactly one cycle):
  - digit_old <= digit_new; digit_new <= decode(latched code).
  - new_key = 1 for this cycle only, registered so it is aligned with the digit update.
  - Then go to HELD.
  - The same key pressed twice yields digit_new = digit_old = that key.
- State HELD:
  - Ignore enable and total_val changes, including a second key pressed while the first is held.
  - If key_pressed = 0: counter = 0, go to RELEASE.
- State RELEASE:
  - While key_pressed = 0: counter++.
  - When counter == DEBOUNCE_CYCLES-1: go to IDLE.
  - If key_pressed = 1 (bounce): counter = 0, return to HELD. No new capture occurs.
- Counter:
  - Saturates; never wraps.
  - Cleared on every state entry.
- Unused state encodings go to IDLE.
- Outputs digit_new and digit_old are registered and hold their values between captures.

Test Plan:
- Reset then idle (DEBOUNCE_CYCLES = 4 for all tests) → digit_new = 0, digit_old = 0, new_key never asserts.
- Single press:
  - Stimulus: total_val = 8'b1000_1011 (row1, col1) with enable pulse and key_pressed high for 10 cycles, then released for 10 cycles.
  - Response: one new_key pulse exactly 4 cycles after CAPTURE entry from enable; digit_new = 4'h2, digit_old = 4'h0; returns to IDLE.
- Bouncy press:
  - Stimulus: key_pressed toggles 1,1,0,1 after enable on code 8'b0001_0111 (row4, col0).
  - Response: no capture; back in IDLE. Then a stable press → digit_new = 4'hE.
- Sequence:
  - Stimulus: press "7" (8'b0010_0111), release, then press "D" (8'b0001_1110).
  - Response: digit_old = 4'h7, digit_new = 4'hD; exactly two new_key pulses.
- Held key, release bounce, and multi-key:
  - Stimulus: hold "5" for 100 cycles with a 2-cycle key_pressed dropout.
  - Response: exactly one capture.
  - Stimulus: enable with code 8'b0100_0011 (two columns low).
  - Response: ignored; busy stays 0.
- Async reset mid-DEBOUNCE and mid-HELD:
  - Response: outputs clear within the same cycle.
  - After reset deasserts, a fresh press captures normally.
